// File: rtl/bram_nread_init.sv
// Multi-read-port RAM that sweeps INIT_VALUE into every word after reset
// before accepting user writes and reads (write-first on address collision).
module bram_nread_init #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_RD = 3,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [ADDR_WIDTH-1:0]        WR_ADDR,
  input  logic [DATA_WIDTH-1:0]        D_IN,
  input  logic                         WE,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] RD_ADDR,
  input  logic [NUM_RD-1:0]            RE,
  output logic [NUM_RD*DATA_WIDTH-1:0] D_OUT,
  output logic [NUM_RD-1:0]            RD_RDY,
  output logic                         INIT_DONE
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
  logic                    arr_we;
  logic [ADDR_WIDTH-1:0]   arr_waddr;
  logic [DATA_WIDTH-1:0]   arr_wdata;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    arr_we    = 1'b0;
    arr_waddr = WR_ADDR;
    arr_wdata = D_IN;
    case (state)
      ST_INIT: begin
        arr_we    = 1'b1;
        arr_waddr = cnt;
        arr_wdata = INIT_VALUE;
        cnt_nxt   = cnt + ADDR_WIDTH'(1);
        if (cnt == {ADDR_WIDTH{1'b1}})
          state_nxt = ST_READY;
      end
      ST_READY: begin
        arr_we = WE;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign INIT_DONE = (state == ST_READY);

  // Storage has no reset; only the sweep gives it defined contents.
  always_ff @(posedge CLK) begin
    if (RST_N && arr_we)
      mem[arr_waddr] <= arr_wdata;
  end

  // Read stage: one registered result per port, user write bypassed on collision.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      D_OUT  <= '0;
      RD_RDY <= '0;
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        RD_RDY[k] <= (state == ST_READY) && RE[k];
        if ((state == ST_READY) && RE[k]) begin
          if (WE && (RD_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH] == WR_ADDR))
            D_OUT[k*DATA_WIDTH +: DATA_WIDTH] <= D_IN;
          else
            D_OUT[k*DATA_WIDTH +: DATA_WIDTH] <= mem[RD_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH]];
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_nread_init.sv
// Directed bench for bram_nread_init: a 3-port 16x8 instance and a 1-port 64x32 instance.
module tb_bram_nread_init;

  logic        CLK;
  int          checks;
  int          failures;

  // 3-port, 16 x 8 instance
  logic        rst_n;
  logic [3:0]  wr_addr;
  logic [7:0]  d_in;
  logic        we;
  logic [11:0] rd_addr;
  logic [2:0]  re;
  logic [23:0] d_out;
  logic [2:0]  rd_rdy;
  logic        init_done;

  // 1-port, 64 x 32 instance
  logic        rst_n1;
  logic [5:0]  wr_addr1;
  logic [31:0] d_in1;
  logic        we1;
  logic [5:0]  rd_addr1;
  logic [0:0]  re1;
  logic [31:0] d_out1;
  logic [0:0]  rd_rdy1;
  logic        init_done1;

  bram_nread_init #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_RD(3), .INIT_VALUE(8'hA5)) u_dut (
    .CLK(CLK), .RST_N(rst_n), .WR_ADDR(wr_addr), .D_IN(d_in), .WE(we),
    .RD_ADDR(rd_addr), .RE(re), .D_OUT(d_out), .RD_RDY(rd_rdy), .INIT_DONE(init_done)
  );

  bram_nread_init #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_RD(1), .INIT_VALUE(32'h0BAD_F00D)) u_dut1 (
    .CLK(CLK), .RST_N(rst_n1), .WR_ADDR(wr_addr1), .D_IN(d_in1), .WE(we1),
    .RD_ADDR(rd_addr1), .RE(re1), .D_OUT(d_out1), .RD_RDY(rd_rdy1), .INIT_DONE(init_done1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0; wr_addr = '0; d_in = '0; we = 1'b0; rd_addr = '0; re = '0;
    rst_n1 = 1'b0; wr_addr1 = '0; d_in1 = '0; we1 = 1'b0; rd_addr1 = '0; re1 = '0;

    // Reset with requests active: nothing observable
    we = 1'b1; re = 3'b111;
    tick(); tick();
    check("rst_dout", 64'(d_out), 64'h0);
    check("rst_rdy", 64'(rd_rdy), 64'h0);
    check("rst_done", 64'(init_done), 64'h0);

    // Init sweep with WE/RE held high throughout
    rst_n = 1'b1; wr_addr = 4'd12; d_in = 8'hFF; rd_addr = {4'd15, 4'd7, 4'd0};
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("init_done_e%0d", i), 64'(init_done), (i == 16) ? 64'h1 : 64'h0);
      check($sformatf("init_rdy_e%0d", i), 64'(rd_rdy), 64'h0);
    end
    check("init_dout_hold", 64'(d_out), 64'h0);

    // First READY edge: reads of 0, 7, 15 (write to 12 does not collide)
    tick();
    check("first_rd_dout", 64'(d_out), 64'hA5A5A5);
    check("first_rd_rdy", 64'(rd_rdy), 64'h7);

    // Basic write then read of address 5
    we = 1'b1; wr_addr = 4'd5; d_in = 8'h3C; re = 3'b000;
    tick();
    check("wr5_rdy", 64'(rd_rdy), 64'h0);
    check("wr5_hold", 64'(d_out), 64'hA5A5A5);
    we = 1'b0; re = 3'b001; rd_addr = {4'd0, 4'd0, 4'd5};
    tick();
    check("rd5_dout0", 64'(d_out[7:0]), 64'h3C);
    check("rd5_rdy", 64'(rd_rdy), 64'h1);
    re = 3'b000;
    tick();
    check("rd5_rdy_clr", 64'(rd_rdy), 64'h0);
    check("rd5_hold", 64'(d_out[7:0]), 64'h3C);

    // Write-first bypass on ports 0/1, old contents on port 2
    we = 1'b1; wr_addr = 4'd9; d_in = 8'h77; re = 3'b111; rd_addr = {4'd10, 4'd9, 4'd9};
    tick();
    check("byp_dout", 64'(d_out), 64'hA57777);
    check("byp_rdy", 64'(rd_rdy), 64'h7);
    we = 1'b0; re = 3'b001; rd_addr = {4'd0, 4'd0, 4'd9};
    tick();
    check("byp_stored", 64'(d_out[7:0]), 64'h77);

    // Hold on port 2 while address 5 is rewritten
    re = 3'b100; rd_addr = {4'd5, 4'd0, 4'd0};
    tick();
    check("hold_rd", 64'(d_out[23:16]), 64'h3C);
    check("hold_rd_rdy", 64'(rd_rdy), 64'h4);
    re = 3'b000; we = 1'b1; wr_addr = 4'd5;
    for (int i = 0; i < 3; i++) begin
      d_in = 8'(8'h11 * (i + 1));
      tick();
      check($sformatf("hold_dout2_c%0d", i), 64'(d_out[23:16]), 64'h3C);
      check($sformatf("hold_rdy_c%0d", i), 64'(rd_rdy), 64'h0);
    end
    we = 1'b0; re = 3'b010; rd_addr = {4'd0, 4'd5, 4'd0};
    tick();
    check("hold_last_wr", 64'(d_out[15:8]), 64'h33);

    // Write address 3 with a non-init value
    we = 1'b1; wr_addr = 4'd3; d_in = 8'hC3; re = 3'b000;
    tick();
    we = 1'b0; re = 3'b001; rd_addr = {4'd0, 4'd0, 4'd3};
    tick();
    check("wr3_rd", 64'(d_out[7:0]), 64'hC3);

    // Reset from READY, partial sweep to cnt=8, reset again
    re = 3'b000;
    rst_n = 1'b0;
    tick();
    check("rst2_dout", 64'(d_out), 64'h0);
    check("rst2_rdy", 64'(rd_rdy), 64'h0);
    check("rst2_done", 64'(init_done), 64'h0);
    rst_n = 1'b1; re = 3'b111; we = 1'b1; wr_addr = 4'd3; d_in = 8'hEE;
    for (int i = 0; i < 8; i++) tick();
    check("mid_done", 64'(init_done), 64'h0);
    check("mid_rdy", 64'(rd_rdy), 64'h0);
    rst_n = 1'b0;
    tick();
    check("rst3_dout", 64'(d_out), 64'h0);
    check("rst3_done", 64'(init_done), 64'h0);
    rst_n = 1'b1; we = 1'b0; re = 3'b000;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("resweep_done_e%0d", i), 64'(init_done), (i == 16) ? 64'h1 : 64'h0);
    end
    re = 3'b011; rd_addr = {4'd0, 4'd12, 4'd3};
    tick();
    check("resweep_rd3", 64'(d_out[7:0]), 64'hA5);
    check("resweep_rd12", 64'(d_out[15:8]), 64'hA5);
    check("resweep_rdy", 64'(rd_rdy), 64'h3);
    re = 3'b000;

    // Single-port 64 x 32 instance
    tick();
    check("p1_rst_dout", 64'(d_out1), 64'h0);
    check("p1_rst_done", 64'(init_done1), 64'h0);
    rst_n1 = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i >= 63)
        check($sformatf("p1_done_e%0d", i), 64'(init_done1), (i == 64) ? 64'h1 : 64'h0);
    end
    we1 = 1'b1; wr_addr1 = 6'd5; d_in1 = 32'hDEAD_BEEF;
    tick();
    we1 = 1'b0; re1 = 1'b1; rd_addr1 = 6'd5;
    tick();
    check("p1_rd5", 64'(d_out1), 64'hDEAD_BEEF);
    check("p1_rd5_rdy", 64'(rd_rdy1), 64'h1);
    re1 = 1'b0;
    tick();
    check("p1_rdy_clr", 64'(rd_rdy1), 64'h0);
    re1 = 1'b1; rd_addr1 = 6'd40;
    tick();
    check("p1_rd40", 64'(d_out1), 64'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
